// File: rtl/br_pkg.sv
// Shared branch-prediction types: the per-instruction record carried from fetch
// to execute, and the sequential-PC increment used by fetch and resolve.
package br_pkg;

  localparam int unsigned BR_PC_W = 32;
  localparam logic [BR_PC_W-1:0] BR_PC_INC = 32'd4;

  typedef struct packed {
    logic [BR_PC_W-1:0] pc;
    logic [BR_PC_W-1:0] next_pc;
    logic               hit;
    logic               taken;
    logic               glb_taken;
    logic               loc_taken;
  } BrqEntry_s;

endpackage

// File: rtl/br_flush_fifo.sv
// Synchronous circular FIFO of prediction records with a single-cycle flush.
// A flush wins over any push or pop presented on the same edge.
module br_flush_fifo
  import br_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_flush,
  input  logic      i_push,
  input  BrqEntry_s i_push_data,
  input  logic      i_pop,
  output BrqEntry_s o_head,
  output logic      o_empty,
  output logic      o_full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  BrqEntry_s     mem_q [DEPTH];
  logic          do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (PW+1)'(DEPTH));
  assign do_push = i_push & ~o_full & ~i_flush;
  assign do_pop  = i_pop & ~o_empty;
  assign o_head  = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observable while counted.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_push_data;
  end

endmodule

// File: rtl/br_resolve_queue.sv
// Holds fetch-time predictions until execute resolves them in order, then emits
// predictor update strobes, the mispredict redirect and branch statistics.
module br_resolve_queue
  import br_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push_vld,
  output logic                o_push_rdy,
  input  logic [PC_WIDTH-1:0] i_push_pc,
  input  logic                i_push_hit,
  input  logic                i_push_taken,
  input  logic                i_push_glb_taken,
  input  logic                i_push_loc_taken,
  input  logic [PC_WIDTH-1:0] i_push_next_pc,
  input  logic                i_res_vld,
  input  logic                i_res_is_br,
  input  logic                i_res_taken,
  input  logic [PC_WIDTH-1:0] i_res_target,
  output logic                o_upd_btb_vld,
  output logic [PC_WIDTH-1:0] o_upd_btb_pc,
  output logic [PC_WIDTH-1:0] o_upd_btb_br_addr,
  output logic                o_upd_pht_vld,
  output logic                o_upd_eval_vld,
  output logic [PC_WIDTH-1:0] o_upd_pht_pc,
  output logic                o_upd_pht_taken,
  output logic                o_upd_pht_pred_glb_taken,
  output logic                o_upd_pht_pred_loc_taken,
  output logic                o_redirect_vld,
  output logic [PC_WIDTH-1:0] o_redirect_pc,
  output logic                o_empty,
  output logic                o_full,
  output logic [CNT_W-1:0]    o_br_cnt,
  output logic [CNT_W-1:0]    o_mispred_cnt
);

  BrqEntry_s           push_ent, head;
  logic [PC_WIDTH-1:0] head_pc, head_next_pc, act_pc;
  logic                pop, mispred, flush;

  logic                btb_vld_q, pht_vld_q, eval_vld_q, redir_vld_q;
  logic                pht_taken_q, glb_q, loc_q;
  logic [PC_WIDTH-1:0] btb_pc_q, btb_addr_q, pht_pc_q, redir_pc_q;
  logic [CNT_W-1:0]    br_cnt_q, mis_cnt_q;

  always_comb begin
    push_ent           = '0;
    push_ent.pc        = BR_PC_W'(i_push_pc);
    push_ent.next_pc   = BR_PC_W'(i_push_next_pc);
    push_ent.hit       = i_push_hit;
    push_ent.taken     = i_push_taken;
    push_ent.glb_taken = i_push_glb_taken;
    push_ent.loc_taken = i_push_loc_taken;
  end

  br_flush_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (flush),
    .i_push      (i_push_vld),
    .i_push_data (push_ent),
    .i_pop       (pop),
    .o_head      (head),
    .o_empty     (o_empty),
    .o_full      (o_full)
  );

  assign o_push_rdy   = ~o_full;
  assign pop          = i_res_vld & ~o_empty;
  assign head_pc      = PC_WIDTH'(head.pc);
  assign head_next_pc = PC_WIDTH'(head.next_pc);
  assign act_pc       = (i_res_is_br & i_res_taken) ? i_res_target
                                                    : head_pc + PC_WIDTH'(BR_PC_INC);
  // A non-branch whose record carries a stale BTB target also mispredicts here.
  assign mispred      = (act_pc != head_next_pc);
  assign flush        = pop & mispred;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      btb_vld_q   <= 1'b0;
      pht_vld_q   <= 1'b0;
      eval_vld_q  <= 1'b0;
      redir_vld_q <= 1'b0;
      pht_taken_q <= 1'b0;
      glb_q       <= 1'b0;
      loc_q       <= 1'b0;
      btb_pc_q    <= '0;
      btb_addr_q  <= '0;
      pht_pc_q    <= '0;
      redir_pc_q  <= '0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      btb_vld_q   <= pop & i_res_is_br & i_res_taken;
      pht_vld_q   <= pop & i_res_is_br;
      eval_vld_q  <= pop & i_res_is_br & head.hit;
      redir_vld_q <= flush;
      if (pop) begin
        pht_taken_q <= i_res_taken;
        glb_q       <= head.glb_taken;
        loc_q       <= head.loc_taken;
        btb_pc_q    <= head_pc;
        btb_addr_q  <= i_res_target;
        pht_pc_q    <= head_pc;
        redir_pc_q  <= act_pc;
        if (i_res_is_br) br_cnt_q <= br_cnt_q + 1'b1;
        if (mispred)     mis_cnt_q <= mis_cnt_q + 1'b1;
      end
    end
  end

  assign o_upd_btb_vld            = btb_vld_q;
  assign o_upd_btb_pc             = btb_pc_q;
  assign o_upd_btb_br_addr        = btb_addr_q;
  assign o_upd_pht_vld            = pht_vld_q;
  assign o_upd_eval_vld           = eval_vld_q;
  assign o_upd_pht_pc             = pht_pc_q;
  assign o_upd_pht_taken          = pht_taken_q;
  assign o_upd_pht_pred_glb_taken = glb_q;
  assign o_upd_pht_pred_loc_taken = loc_q;
  assign o_redirect_vld           = redir_vld_q;
  assign o_redirect_pc            = redir_pc_q;
  assign o_br_cnt                 = br_cnt_q;
  assign o_mispred_cnt            = mis_cnt_q;

endmodule

// File: tb/tb_br_resolve_queue.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// random traffic, all compared against a queue-based reference model.
module tb_br_resolve_queue;

  localparam int PCW = 32;
  localparam int DEPTH = 4;
  localparam int CNTW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            push_vld = 0, push_hit = 0, push_taken = 0, push_glb = 0, push_loc = 0;
  logic [PCW-1:0]  push_pc = '0, push_next = '0, res_target = '0;
  logic            res_vld = 0, res_is_br = 0, res_taken = 0;
  logic            push_rdy, btb_vld, pht_vld, eval_vld, pht_taken, pred_glb, pred_loc;
  logic            redir_vld, empty, full;
  logic [PCW-1:0]  btb_pc, btb_addr, pht_pc, redir_pc;
  logic [CNTW-1:0] br_cnt, mis_cnt;

  always #5 clk = ~clk;

  br_resolve_queue #(.PC_WIDTH(PCW), .DEPTH(DEPTH), .CNT_W(CNTW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_push_vld(push_vld), .o_push_rdy(push_rdy), .i_push_pc(push_pc),
    .i_push_hit(push_hit), .i_push_taken(push_taken),
    .i_push_glb_taken(push_glb), .i_push_loc_taken(push_loc),
    .i_push_next_pc(push_next),
    .i_res_vld(res_vld), .i_res_is_br(res_is_br), .i_res_taken(res_taken),
    .i_res_target(res_target),
    .o_upd_btb_vld(btb_vld), .o_upd_btb_pc(btb_pc), .o_upd_btb_br_addr(btb_addr),
    .o_upd_pht_vld(pht_vld), .o_upd_eval_vld(eval_vld), .o_upd_pht_pc(pht_pc),
    .o_upd_pht_taken(pht_taken), .o_upd_pht_pred_glb_taken(pred_glb),
    .o_upd_pht_pred_loc_taken(pred_loc),
    .o_redirect_vld(redir_vld), .o_redirect_pc(redir_pc),
    .o_empty(empty), .o_full(full), .o_br_cnt(br_cnt), .o_mispred_cnt(mis_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [PCW-1:0] pc, nxt; bit hit, glb, loc; } rec_t;
  rec_t ref_q[$];
  bit m_btb, m_pht, m_eval, m_redir, m_ptaken, m_glb, m_loc;
  logic [PCW-1:0] m_btb_pc, m_btb_addr, m_pht_pc, m_redir_pc;
  logic [CNTW-1:0] m_br, m_mis;

  task automatic model_reset();
    ref_q.delete();
    {m_btb, m_pht, m_eval, m_redir, m_ptaken, m_glb, m_loc} = '0;
    {m_btb_pc, m_btb_addr, m_pht_pc, m_redir_pc} = '0;
    m_br = 0; m_mis = 0;
  endtask

  task automatic model_step();
    bit room, miss;
    rec_t h, n;
    logic [PCW-1:0] act;
    room = ref_q.size() < DEPTH;
    miss = 0;
    {m_btb, m_pht, m_eval, m_redir} = '0;
    if (res_vld && ref_q.size() > 0) begin
      h = ref_q.pop_front();
      act = (res_is_br && res_taken) ? res_target : h.pc + 32'd4;
      miss = (act != h.nxt);
      m_pht = res_is_br; m_eval = res_is_br && h.hit; m_btb = res_is_br && res_taken;
      m_redir = miss; m_redir_pc = act;
      m_btb_pc = h.pc; m_btb_addr = res_target; m_pht_pc = h.pc;
      m_ptaken = res_taken; m_glb = h.glb; m_loc = h.loc;
      if (res_is_br) m_br++;
      if (miss) begin m_mis++; ref_q.delete(); end
    end
    if (push_vld && room && !miss) begin
      n.pc = push_pc; n.nxt = push_next; n.hit = push_hit; n.glb = push_glb; n.loc = push_loc;
      ref_q.push_back(n);
    end
  endtask

  task automatic compare_all();
    chk("strobes", {btb_vld, pht_vld, eval_vld, redir_vld}, {m_btb, m_pht, m_eval, m_redir});
    chk("pht_bits", {pht_taken, pred_glb, pred_loc}, {m_ptaken, m_glb, m_loc});
    chk("pcs", {btb_pc, btb_addr, pht_pc, redir_pc}, {m_btb_pc, m_btb_addr, m_pht_pc, m_redir_pc});
    chk("counters", {br_cnt, mis_cnt}, {m_br, m_mis});
    chk("status", {empty, full, push_rdy},
        {ref_q.size() == 0, ref_q.size() == DEPTH, ref_q.size() < DEPTH});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit pv, input logic [PCW-1:0] pc, input bit hit, input bit tk,
                       input bit glb, input bit loc, input logic [PCW-1:0] nxt,
                       input bit rv, input bit br, input bit rtk, input logic [PCW-1:0] tgt);
    push_vld = pv; push_pc = pc; push_hit = hit; push_taken = tk; push_glb = glb;
    push_loc = loc; push_next = nxt;
    res_vld = rv; res_is_br = br; res_taken = rtk; res_target = tgt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
    compare_all();
  endtask

  task automatic push(input logic [PCW-1:0] pc, input logic [PCW-1:0] nxt);
    drive(1, pc, 0, 0, 0, 0, nxt, 0, 0, 0, '0);
    cycle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit pv; logic [PCW-1:0] pc; bit hit, tk, glb, loc; logic [PCW-1:0] nxt;
    bit rv, br, rtk; logic [PCW-1:0] tgt;
    bit e_pht, e_eval, e_btb, e_redir; logic [PCW-1:0] e_rpc;
    logic [CNTW-1:0] e_br, e_mis; bit e_empty;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{1, 32'h100, 0, 0, 0, 0, 32'h104, 0, 0, 0, 0,     0, 0, 0, 0, 32'h0,   0, 0, 0};
    vt[1] = '{0, 0,       0, 0, 0, 0, 0,       1, 1, 0, 0,     1, 0, 0, 0, 32'h104, 1, 0, 1};
    vt[2] = '{1, 32'h200, 1, 0, 1, 0, 32'h204, 0, 0, 0, 0,     0, 0, 0, 0, 32'h104, 1, 0, 0};
    vt[3] = '{0, 0,       0, 0, 0, 0, 0,       1, 1, 1, 32'h300, 1, 1, 1, 1, 32'h300, 2, 1, 1};
    vt[4] = '{1, 32'h400, 1, 1, 0, 0, 32'h500, 0, 0, 0, 0,     0, 0, 0, 0, 32'h300, 2, 1, 0};
    vt[5] = '{0, 0,       0, 0, 0, 0, 0,       1, 0, 0, 0,     0, 0, 0, 1, 32'h404, 2, 2, 1};
    vt[6] = '{0, 0,       0, 0, 0, 0, 0,       1, 1, 1, 32'h900, 0, 0, 0, 0, 32'h404, 2, 2, 1};

    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    do_reset();
    chk("reset_outputs", {btb_vld, pht_vld, eval_vld, redir_vld, empty, full, push_rdy, redir_pc, br_cnt},
        {4'b0000, 3'b101, 32'h0, 32'h0});

    for (int i = 0; i < 7; i++) begin
      drive(vt[i].pv, vt[i].pc, vt[i].hit, vt[i].tk, vt[i].glb, vt[i].loc, vt[i].nxt,
            vt[i].rv, vt[i].br, vt[i].rtk, vt[i].tgt);
      cycle();
      chk($sformatf("vec%0d_strobes", i), {pht_vld, eval_vld, btb_vld, redir_vld},
          {vt[i].e_pht, vt[i].e_eval, vt[i].e_btb, vt[i].e_redir});
      chk($sformatf("vec%0d_redir_pc", i), redir_pc, vt[i].e_rpc);
      chk($sformatf("vec%0d_counts", i), {br_cnt, mis_cnt, empty}, {vt[i].e_br, vt[i].e_mis, vt[i].e_empty});
      if (i == 3) chk("vec3_btb_glb_loc", {btb_addr, pred_glb, pred_loc}, {32'h300, 2'b10});
    end

    // Fill to full, held-off fifth push, then pop and push+pop at steady count.
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 16), 32'h1004 + 32'(i * 16));
    chk("full_flag", {full, push_rdy}, 2'b10);
    push(32'h5000, 32'h5004);
    chk("held_off", {full, push_rdy}, 2'b10);
    drive(1, 32'h6000, 0, 0, 0, 0, 32'h6004, 1, 0, 0, '0);
    cycle();
    chk("no_push_through", {full, redir_vld}, 2'b00);
    drive(1, 32'h7000, 0, 0, 0, 0, 32'h7004, 1, 1, 0, '0);
    cycle();
    chk("push_pop_keep", {full, empty, pht_pc}, {2'b00, 32'h1010});
    push(32'h7100, 32'h7104);
    chk("refill_full", full, 1'b1);

    // Mispredict flush with a simultaneous, dropped push.
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h2000 + 32'(i * 4), 32'h2004 + 32'(i * 4));
    drive(1, 32'h8000, 0, 0, 0, 0, 32'h8004, 1, 1, 1, 32'h3000);
    cycle();
    chk("flush_empty", {empty, redir_vld, redir_pc}, {2'b11, 32'h3000});
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, '0);
    cycle();
    chk("dropped_never_resolved", {pht_vld, redir_vld, br_cnt}, {2'b00, 32'd1});

    // Reset with entries queued.
    push(32'ha000, 32'ha004);
    push(32'ha004, 32'ha008);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    do_reset();
    chk("midop_reset", {empty, br_cnt, mis_cnt}, {1'b1, 64'h0});

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rec_t h;
      logic [PCW-1:0] pc, nxt;
      pc = $urandom() & 32'hffff_fffc;
      nxt = ($urandom_range(1) == 0) ? pc + 32'd4 : ($urandom() & 32'hffff_fffc);
      drive(($urandom_range(2) != 0), pc, 1'($urandom()), 1'($urandom()), 1'($urandom()),
            1'($urandom()), nxt, 1'($urandom()), 1'($urandom()), 1'($urandom()),
            $urandom() & 32'hffff_fffc);
      if (ref_q.size() > 0 && $urandom_range(3) != 0) begin
        h = ref_q[0];
        if (h.nxt == h.pc + 32'd4) begin
          res_taken = 1'b0;
        end else begin
          res_is_br = 1'b1; res_taken = 1'b1; res_target = h.nxt;
        end
      end
      if (n == 300) rst_n = 1'b0;
      if (!rst_n) begin
        @(posedge clk); model_reset(); #1; rst_n = 1'b1; compare_all();
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
